// File: rtl/fwd_hazard_if.sv
// Bundle of EX-stage, result-stage and forwarding signals for fwd_hazard_unit.
// Counter outputs exist only when FWD_HAZARD_STATS_EN is defined.
interface fwd_hazard_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int DEPTH = 2
);
  logic                    ex_valid;
  logic [NSRC*AW-1:0]      ex_rs;
  logic [AW-1:0]           ex_rd;
  logic                    ex_we;
  logic                    ex_is_load;
  logic [NSRC*XLEN-1:0]    ex_opnd;
  logic [DEPTH*XLEN-1:0]   stg_data;
  logic                    flush;
  logic [NSRC*XLEN-1:0]    fwd_opnd;
  logic [NSRC-1:0]         fwd_hit;
  logic                    stall;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]             fwd_cnt;
  logic [31:0]             stall_cnt;
`endif

  modport master (
    output ex_valid, ex_rs, ex_rd, ex_we, ex_is_load, ex_opnd, stg_data, flush,
    input  fwd_opnd, fwd_hit, stall
`ifdef FWD_HAZARD_STATS_EN
    , input fwd_cnt, stall_cnt
`endif
  );

  modport slave (
    input  ex_valid, ex_rs, ex_rd, ex_we, ex_is_load, ex_opnd, stg_data, flush,
    output fwd_opnd, fwd_hit, stall
`ifdef FWD_HAZARD_STATS_EN
    , output fwd_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall detection over a DEPTH-stage tag pipeline.
// Define FWD_HAZARD_STATS_EN to add saturating forward/stall event counters.
module fwd_hazard_unit #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fwd_hazard_if.slave  bus
);

  logic [DEPTH:1] tag_valid;
  logic [DEPTH:1] tag_we;
  logic [DEPTH:1] tag_load;
  logic [AW-1:0]  tag_rd [1:DEPTH];

  logic [NSRC-1:0] load_hit;
  logic [AW-1:0]   rs;

  // Scan oldest to youngest so the lowest-numbered matching stage wins.
  always_comb begin
    bus.fwd_opnd = bus.ex_opnd;
    bus.fwd_hit  = '0;
    load_hit     = '0;
    rs           = '0;
    for (int i = 0; i < NSRC; i++) begin
      rs = bus.ex_rs[i*AW +: AW];
      if (rs == '0) begin
        bus.fwd_opnd[i*XLEN +: XLEN] = '0;
      end else begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (tag_valid[k] && tag_we[k] && (tag_rd[k] == rs)) begin
            bus.fwd_opnd[i*XLEN +: XLEN] = bus.stg_data[(k-1)*XLEN +: XLEN];
            bus.fwd_hit[i]               = 1'b1;
            load_hit[i]                  = (k == 1) && tag_load[1];
          end
        end
      end
    end
  end

  assign bus.stall = bus.ex_valid & ~bus.flush & (|load_hit);

  // A stalled or flushed EX instruction enters the pipeline as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_we    <= '0;
      tag_load  <= '0;
      for (int k = 1; k <= DEPTH; k++) tag_rd[k] <= '0;
    end else begin
      tag_valid[DEPTH:2] <= tag_valid[DEPTH-1:1];
      tag_we[DEPTH:2]    <= tag_we[DEPTH-1:1];
      tag_load[DEPTH:2]  <= tag_load[DEPTH-1:1];
      for (int k = 2; k <= DEPTH; k++) tag_rd[k] <= tag_rd[k-1];
      tag_valid[1] <= bus.ex_valid & ~bus.flush & ~bus.stall;
      tag_we[1]    <= bus.ex_we;
      tag_load[1]  <= bus.ex_is_load;
      tag_rd[1]    <= bus.ex_rd;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [2:0]  hit_pop;
  logic [32:0] fwd_sum;

  always_comb begin
    hit_pop = '0;
    for (int i = 0; i < NSRC; i++) hit_pop = hit_pop + 3'(bus.fwd_hit[i]);
  end

  assign fwd_sum = {1'b0, fwd_cnt_q} + 33'(hit_pop);

  // Forwards count only for instructions that actually leave EX this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.ex_valid && !bus.stall && !bus.flush)
        fwd_cnt_q <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      if (bus.stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.fwd_cnt   = fwd_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized traffic
// compared against a queue-based history model of issued instructions.
module tb_fwd_hazard_unit;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NSRC  = 2;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_if #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH)) bus();

  fwd_hazard_unit #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          v;
    logic [AW-1:0] rd;
    logic          we;
    logic          ld;
  } hist_t;

  // Most recently retired-from-EX instruction at the front (= MEM stage).
  hist_t hist[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic [NSRC*XLEN-1:0] e_opnd;
  logic [NSRC-1:0]      e_hit;
  logic                 e_stall;
  logic [31:0]          m_fwd_cnt = 0;
  logic [31:0]          m_stall_cnt = 0;

  function automatic void model_eval(output logic [NSRC*XLEN-1:0] o,
                                     output logic [NSRC-1:0] h, output logic s);
    logic [AW-1:0] r;
    logic found;
    o = bus.ex_opnd;
    h = '0;
    s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      r = bus.ex_rs[i*AW +: AW];
      found = 1'b0;
      if (r == 0) o[i*XLEN +: XLEN] = '0;
      else
        for (int k = 0; k < hist.size(); k++)
          if (!found && hist[k].v && hist[k].we && hist[k].rd == r) begin
            found = 1'b1;
            o[i*XLEN +: XLEN] = bus.stg_data[k*XLEN +: XLEN];
            h[i] = 1'b1;
            if (k == 0 && hist[k].ld) s = 1'b1;
          end
    end
    s = s & bus.ex_valid & ~bus.flush;
  endfunction

  task automatic tick();
    logic [32:0] sum;
    hist_t t;
    model_eval(e_opnd, e_hit, e_stall);
    if (rst_n) begin
      if (bus.ex_valid && !e_stall && !bus.flush) begin
        sum = {1'b0, m_fwd_cnt} + 33'($countones(e_hit));
        m_fwd_cnt = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      end
      if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
      t.v = bus.ex_valid & ~bus.flush & ~e_stall;
      t.rd = bus.ex_rd;
      t.we = bus.ex_we;
      t.ld = bus.ex_is_load;
      hist.push_front(t);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ex_valid   = 1'b0;
    bus.ex_rs      = '0;
    bus.ex_rd      = '0;
    bus.ex_we      = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.flush      = 1'b0;
    bus.ex_opnd    = {$urandom, $urandom};
    bus.stg_data   = {$urandom, $urandom, $urandom};
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic we, input logic ld);
    drive_idle();
    bus.ex_valid   = 1'b1;
    bus.ex_rd      = rd;
    bus.ex_we      = we;
    bus.ex_is_load = ld;
    tick();
  endtask

  task automatic test_reset();
    drive_idle();
    bus.ex_valid = 1'b1;
    bus.ex_rs = {5'd0, 5'd4};
    #2;
    model_eval(e_opnd, e_hit, e_stall);
    n_checks++; if (bus.fwd_hit !== '0) $display("[TB] FAIL reset_hit got %b want 0", bus.fwd_hit); else n_pass++;
    n_checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL reset_stall got %b want 0", bus.stall); else n_pass++;
    n_checks++; if (bus.fwd_opnd !== e_opnd) $display("[TB] FAIL reset_opnd got %h want %h", bus.fwd_opnd, e_opnd); else n_pass++;
`ifdef FWD_HAZARD_STATS_EN
    n_checks++; if (bus.fwd_cnt !== 0 || bus.stall_cnt !== 0) $display("[TB] FAIL reset_cnt got %0d/%0d want 0/0", bus.fwd_cnt, bus.stall_cnt); else n_pass++;
`endif
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    issue(5'd5, 1'b1, 1'b0);
    drive_idle();
    bus.stg_data[0 +: XLEN] = 32'h11;
    bus.ex_valid = 1'b1;
    bus.ex_rs[0 +: AW] = 5'd5;
    #1;
    n_checks++; if (bus.fwd_opnd[0 +: XLEN] !== 32'h11) $display("[TB] FAIL b2b_opnd got %h want 11", bus.fwd_opnd[0 +: XLEN]); else n_pass++;
    n_checks++; if (bus.fwd_hit[0] !== 1'b1) $display("[TB] FAIL b2b_hit got %b want 1", bus.fwd_hit[0]); else n_pass++;
    n_checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL b2b_stall got %b want 0", bus.stall); else n_pass++;
    tick();
  endtask

  task automatic test_priority();
    issue(5'd7, 1'b1, 1'b0);
    issue(5'd7, 1'b1, 1'b0);
    drive_idle();
    bus.stg_data[0 +: XLEN] = 32'hAA;
    bus.stg_data[XLEN +: XLEN] = 32'hBB;
    bus.ex_valid = 1'b1;
    bus.ex_rs[AW +: AW] = 5'd7;
    #1;
    n_checks++; if (bus.fwd_opnd[XLEN +: XLEN] !== 32'hAA) $display("[TB] FAIL prio_opnd got %h want aa", bus.fwd_opnd[XLEN +: XLEN]); else n_pass++;
    n_checks++; if (bus.fwd_hit !== 2'b10) $display("[TB] FAIL prio_hit got %b want 10", bus.fwd_hit); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] sc0;
    issue(5'd3, 1'b1, 1'b1);
    drive_idle();
    bus.ex_valid = 1'b1;
    bus.ex_rs[0 +: AW] = 5'd3;
    #1;
    n_checks++; if (bus.stall !== 1'b1) $display("[TB] FAIL lu_stall got %b want 1", bus.stall); else n_pass++;
    sc0 = m_stall_cnt;
    tick();
    bus.stg_data[XLEN +: XLEN] = 32'h1234;
    #1;
    n_checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL lu_stall_end got %b want 0", bus.stall); else n_pass++;
    n_checks++; if (bus.fwd_opnd[0 +: XLEN] !== 32'h1234) $display("[TB] FAIL lu_opnd got %h want 1234", bus.fwd_opnd[0 +: XLEN]); else n_pass++;
    n_checks++; if (bus.fwd_hit[0] !== 1'b1) $display("[TB] FAIL lu_hit got %b want 1", bus.fwd_hit[0]); else n_pass++;
`ifdef FWD_HAZARD_STATS_EN
    n_checks++; if (bus.stall_cnt !== sc0 + 1) $display("[TB] FAIL lu_stall_cnt got %0d want %0d", bus.stall_cnt, sc0 + 1); else n_pass++;
`endif
    tick();
  endtask

  task automatic test_x0();
    issue(5'd0, 1'b1, 1'b0);
    drive_idle();
    bus.ex_valid = 1'b1;
    bus.ex_opnd[0 +: XLEN] = 32'hFFFF;
    bus.stg_data[0 +: XLEN] = 32'hDEAD;
    #1;
    n_checks++; if (bus.fwd_opnd[0 +: XLEN] !== 32'h0) $display("[TB] FAIL x0_opnd got %h want 0", bus.fwd_opnd[0 +: XLEN]); else n_pass++;
    n_checks++; if (bus.fwd_hit[0] !== 1'b0) $display("[TB] FAIL x0_hit got %b want 0", bus.fwd_hit[0]); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    issue(5'd3, 1'b1, 1'b1);
    drive_idle();
    bus.ex_valid = 1'b1;
    bus.ex_rs[0 +: AW] = 5'd3;
    bus.ex_rd = 5'd9;
    bus.ex_we = 1'b1;
    bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL flush_stall got %b want 0", bus.stall); else n_pass++;
    tick();
    drive_idle();
    bus.ex_valid = 1'b1;
    bus.ex_rs = {5'd3, 5'd9};
    #1;
    n_checks++; if (bus.fwd_hit[0] !== 1'b0) $display("[TB] FAIL flush_bubble_hit got %b want 0", bus.fwd_hit[0]); else n_pass++;
    n_checks++; if (bus.fwd_opnd[0 +: XLEN] !== bus.ex_opnd[0 +: XLEN]) $display("[TB] FAIL flush_bubble_opnd got %h want %h", bus.fwd_opnd[0 +: XLEN], bus.ex_opnd[0 +: XLEN]); else n_pass++;
    n_checks++; if (bus.fwd_opnd[XLEN +: XLEN] !== bus.stg_data[XLEN +: XLEN] || bus.stall !== 1'b0) $display("[TB] FAIL flush_stage2 got %h/%b want %h/0", bus.fwd_opnd[XLEN +: XLEN], bus.stall, bus.stg_data[XLEN +: XLEN]); else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    issue(5'd3, 1'b1, 1'b1);
    drive_idle();
    bus.ex_valid = 1'b1;
    bus.ex_rs[0 +: AW] = 5'd3;
    #1;
    n_checks++; if (bus.stall !== 1'b1) $display("[TB] FAIL ar_pre_stall got %b want 1", bus.stall); else n_pass++;
    #2;
    rst_n = 1'b0;
    hist.delete();
    m_fwd_cnt = 0;
    m_stall_cnt = 0;
    #1;
    n_checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL ar_stall got %b want 0", bus.stall); else n_pass++;
    n_checks++; if (bus.fwd_hit !== '0) $display("[TB] FAIL ar_hit got %b want 0", bus.fwd_hit); else n_pass++;
`ifdef FWD_HAZARD_STATS_EN
    n_checks++; if (bus.fwd_cnt !== 0 || bus.stall_cnt !== 0) $display("[TB] FAIL ar_cnt got %0d/%0d want 0/0", bus.fwd_cnt, bus.stall_cnt); else n_pass++;
`endif
    tick();
    rst_n = 1'b1;
    issue(5'd6, 1'b1, 1'b0);
    drive_idle();
    bus.ex_valid = 1'b1;
    bus.ex_rs[0 +: AW] = 5'd6;
    #1;
    n_checks++; if (bus.fwd_hit[0] !== 1'b1 || bus.fwd_opnd[0 +: XLEN] !== bus.stg_data[0 +: XLEN]) $display("[TB] FAIL ar_post got %b/%h want 1/%h", bus.fwd_hit[0], bus.fwd_opnd[0 +: XLEN], bus.stg_data[0 +: XLEN]); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_idle();
      bus.ex_valid   = ($urandom_range(0, 9) != 0);
      bus.ex_rs      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      bus.ex_rd      = 5'($urandom_range(0, 3));
      bus.ex_we      = ($urandom_range(0, 3) != 0);
      bus.ex_is_load = ($urandom_range(0, 2) == 0);
      bus.flush      = ($urandom_range(0, 7) == 0);
      #1;
      model_eval(e_opnd, e_hit, e_stall);
      n_checks++; if (bus.fwd_opnd !== e_opnd) $display("[TB] FAIL rnd_opnd cyc %0d got %h want %h", n, bus.fwd_opnd, e_opnd); else n_pass++;
      n_checks++; if (bus.fwd_hit !== e_hit) $display("[TB] FAIL rnd_hit cyc %0d got %b want %b", n, bus.fwd_hit, e_hit); else n_pass++;
      n_checks++; if (bus.stall !== e_stall) $display("[TB] FAIL rnd_stall cyc %0d got %b want %b", n, bus.stall, e_stall); else n_pass++;
`ifdef FWD_HAZARD_STATS_EN
      n_checks++; if (bus.fwd_cnt !== m_fwd_cnt || bus.stall_cnt !== m_stall_cnt) $display("[TB] FAIL rnd_cnt cyc %0d got %0d/%0d want %0d/%0d", n, bus.fwd_cnt, bus.stall_cnt, m_fwd_cnt, m_stall_cnt); else n_pass++;
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_priority();
    test_load_use();
    test_x0();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter NSRC, default 2, number of EX-stage source operands (1..4).
REQ-004 SHALL have parameter DEPTH, default 2, number of post-EX result stages tracked (2..6); stage 1 = MEM.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 ex_valid  input  1  valid instruction in EX.
REQ-008 ex_rs  input  NSRC*AW  source register indices; slice i = source i.
REQ-009 ex_rd / ex_we / ex_is_load  input  AW/1/1  EX destination, write enable, load flag.
REQ-010 ex_opnd  input  NSRC*XLEN  register-file values for each source.
REQ-011 stg_data  input  DEPTH*XLEN  result of stage k in slice k-1.
REQ-012 flush  input  1  kill EX instruction (redirect).
REQ-013 fwd_opnd  output  NSRC*XLEN  resolved operand per source.
REQ-014 fwd_hit  output  NSRC  source i taken from a pipeline stage.
REQ-015 stall  output  1  load-use hazard; EX must hold, consumer must not capture.

Function
REQ-016 SHALL keep internal tag pipeline tag[1..DEPTH] of {valid, rd, we, is_load}.
REQ-017 Each rising edge, tag[k] <= tag[k-1] for k=2..DEPTH.
REQ-018 tag[1] <= {ex_valid & ~flush & ~stall, ex_rd, ex_we, ex_is_load}; bubble (valid=0) on stall or flush.
REQ-019 Source i matches stage k iff tag[k].valid & tag[k].we & tag[k].rd==rs_i & rs_i!=0.
REQ-020 Youngest (lowest k) match SHALL win; fwd_opnd_i = stg_data[k], fwd_hit_i=1.
REQ-021 No match: fwd_opnd_i = ex_opnd_i, fwd_hit_i=0; rs_i==0: fwd_opnd_i = 0, fwd_hit_i=0, regardless of tags.
REQ-022 stall SHALL be combinational = ex_valid & ~flush & (any source's winning match is stage 1 with is_load).
REQ-023 Stall lasts exactly one cycle per load: next cycle the load is at stage 2 and forwards from stg_data[2].
REQ-024 During stall, fwd_opnd/fwd_hit reflect REQ-020 selection but SHALL NOT be counted or relied on.
REQ-025 flush and hazard same cycle: flush wins, stall=0, bubble enters tag[1].
REQ-026 ex_we=0 or ex_valid=0 instructions SHALL never produce matches.
REQ-027 fwd_opnd/fwd_hit/stall SHALL be purely combinational from inputs and tags (zero latency).

Reset
REQ-028 rst_n low SHALL immediately clear all tag valid bits (and counters, REQ-031) without clk.
REQ-029 In reset: stall=0, fwd_hit=0, fwd_opnd=ex_opnd (0 where rs_i==0).
REQ-030 Reset mid-stall: stall drops immediately; first post-reset edge loads tag[1] from EX normally.

Configuration
REQ-031 Macro FWD_HAZARD_STATS_EN defined: SHALL add outputs fwd_cnt (32) and stall_cnt (32); fwd_cnt += popcount(fwd_hit) on each cycle with ex_valid & ~stall & ~flush; stall_cnt += 1 per stall cycle; both saturate at 0xFFFFFFFF, cleared by reset.
REQ-032 Macro undefined: SHALL have no counter ports or logic; all other behaviour identical.

Verification
REQ-033 Back-to-back: EX1 rd=5 we=1 (stg_data[0]=0x11), next EX rs0=5 -> fwd_opnd0=0x11, fwd_hit0=1, stall=0.
REQ-034 Priority: rd=7 at stage1 (0xAA) and stage2 (0xBB), rs1=7 -> fwd_opnd1=0xAA.
REQ-035 Load-use: load rd=3 at stage1, EX rs0=3 -> stall=1 one cycle; next cycle fwd from stg_data[1]=0x1234, stall=0; stall_cnt=1 with macro.
REQ-036 x0: tag rd=0 we=1 at stage1, EX rs0=0, ex_opnd0=0xFFFF -> fwd_opnd0=0, fwd_hit0=0.
REQ-037 Flush: load rd=3 at stage1 + flush=1, EX rs0=3 -> stall=0; next cycle tag[1] invalid, no match.
REQ-038 Async reset with tags valid mid-cycle -> fwd_hit=0, stall=0 before next edge; counters 0.
